// File: rtl/downsampler_frame_sequencer.sv
// Frame-level controller for the grayscale binning downsampler: gates pixels in,
// tracks raster position, counts binned outputs and reports frame status/errors.
module downsampler_frame_sequencer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int BIN_WIDTH    = 2,
    parameter int BIN_HEIGHT   = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    input  logic [DATA_WIDTH-1:0]  pix_data,
    output logic                   ds_reset,
    output logic                   ds_valid,
    output logic [DATA_WIDTH-1:0]  ds_data,
    input  logic                   ds_out_valid,
    output logic                   busy,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_out_count,
    output logic                   err_early_sof,
    output logic                   err_overrun,
    output logic                   err_count,
    input  logic                   err_clear
);

    localparam int EXPECTED = ((IMAGE_WIDTH + BIN_WIDTH - 1) / BIN_WIDTH) *
                              ((IMAGE_HEIGHT + BIN_HEIGHT - 1) / BIN_HEIGHT);
    localparam int XW  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [XW-1:0]          X_LAST    = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0]          Y_LAST    = YW'(IMAGE_HEIGHT - 1);
    localparam logic [DCW-1:0]         D_LAST    = DCW'(DRAIN_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] EXP_COUNT = COUNT_WIDTH'(EXPECTED);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                 state;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [DCW-1:0]         drain_count;
    logic [COUNT_WIDTH-1:0] out_count;
    logic [COUNT_WIDTH-1:0] out_count_next;

    // Saturating output count including this cycle's strobe
    always_comb begin
        out_count_next = out_count;
        if (ds_out_valid && (out_count != '1))
            out_count_next = out_count + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            drain_count     <= '0;
            out_count       <= '0;
            ds_reset        <= 1'b1;
            ds_valid        <= 1'b0;
            ds_data         <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            frame_out_count <= '0;
            err_early_sof   <= 1'b0;
            err_overrun     <= 1'b0;
            err_count       <= 1'b0;
        end else begin
            ds_valid   <= 1'b0;
            frame_done <= 1'b0;
            // Clear first so a set event later in this block takes priority
            if (err_clear) begin
                err_early_sof <= 1'b0;
                err_overrun   <= 1'b0;
                err_count     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    ds_reset <= 1'b1;
                    if (enable && pix_valid && pix_sof) begin
                        ds_reset  <= 1'b0;
                        ds_valid  <= 1'b1;
                        ds_data   <= pix_data;
                        x         <= XW'(1);
                        y         <= '0;
                        out_count <= '0;
                        busy      <= 1'b1;
                        state     <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    out_count <= out_count_next;
                    if (pix_valid && pix_sof) begin
                        err_early_sof <= 1'b1;
                        ds_reset      <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else if (pix_valid) begin
                        ds_valid <= 1'b1;
                        ds_data  <= pix_data;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                drain_count <= '0;
                                state       <= DRAIN;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    out_count   <= out_count_next;
                    drain_count <= drain_count + 1'b1;
                    if (pix_valid)
                        err_overrun <= 1'b1;
                    // Final drain cycle: publish the frame result and re-hold the downsampler
                    if (drain_count == D_LAST) begin
                        frame_done      <= 1'b1;
                        frame_out_count <= out_count_next;
                        if (out_count_next != EXP_COUNT)
                            err_count <= 1'b1;
                        ds_reset <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    ds_reset <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downsampler_frame_sequencer.sv
// Directed bench for downsampler_frame_sequencer on a 4x2 frame with 2x2 bins;
// forwarded pixels are matched against a queue of expected data.
module tb_downsampler_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BW = 2;
    localparam int BH = 2;
    localparam int DW = 8;
    localparam int DC = 4;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          pix_valid;
    logic          pix_sof;
    logic [DW-1:0] pix_data;
    logic          ds_reset;
    logic          ds_valid;
    logic [DW-1:0] ds_data;
    logic          ds_out_valid;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_out_count;
    logic          err_early_sof;
    logic          err_overrun;
    logic          err_count;
    logic          err_clear;

    int            nChecks   = 0;
    int            nErrors   = 0;
    int            doneCount = 0;
    int            fwdCount  = 0;
    logic [DW-1:0] expQ[$];

    always #5 clock = ~clock;

    downsampler_frame_sequencer #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BIN_WIDTH(BW), .BIN_HEIGHT(BH),
        .DATA_WIDTH(DW), .DRAIN_CYCLES(DC), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .ds_reset(ds_reset), .ds_valid(ds_valid), .ds_data(ds_data),
        .ds_out_valid(ds_out_valid), .busy(busy), .frame_done(frame_done),
        .frame_out_count(frame_out_count), .err_early_sof(err_early_sof),
        .err_overrun(err_overrun), .err_count(err_count), .err_clear(err_clear)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle past the monitor
    task automatic applyStimulus(input logic v, input logic sof, input logic [DW-1:0] d,
                                 input logic outv, input logic clr);
        @(negedge clock);
        pix_valid    = v;
        pix_sof      = sof;
        pix_data     = d;
        ds_out_valid = outv;
        err_clear    = clr;
        #1;
    endtask

    // One 8-pixel frame followed by the four drain cycles and one settling cycle
    task automatic doFrame(input logic [DW-1:0] base, input bit gapped, input logic [3:0] outMask,
                           input logic [3:0] pixMask, input bit clearOnLast);
        for (int i = 0; i < W*H; i++) begin
            applyStimulus(1'b1, i == 0, base + DW'(i), 1'b0, 1'b0);
            expQ.push_back(base + DW'(i));
            if (gapped && i < W*H-1)
                applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        for (int d = 0; d < DC; d++) begin
            applyStimulus(pixMask[d], 1'b0, 8'hEE, outMask[d], clearOnLast && (d == DC-1));
            if (d == 1)
                checkOutput("busy in drain", busy, 1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    always @(negedge clock) begin
        if (ds_valid === 1'b1) begin
            fwdCount++;
            checkOutput("forward expected", expQ.size() > 0, 1);
            if (expQ.size() > 0)
                checkOutput("ds_data", ds_data, expQ.pop_front());
            checkOutput("ds_reset while forwarding", ds_reset, 0);
        end
        if (frame_done === 1'b1)
            doneCount++;
    end

    initial begin
        int d0;
        int f0;
        reset = 1'b1; enable = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
        pix_data = '0; ds_out_valid = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset ds_reset", ds_reset, 1);
        checkOutput("reset ds_valid", ds_valid, 0);
        checkOutput("reset ds_data", ds_data, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset frame_out_count", frame_out_count, 0);
        checkOutput("reset errors", {err_early_sof, err_overrun, err_count}, 0);
        reset = 1'b0;

        // Idle drops: non-SOF pixel, and SOF while disabled
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clock); enable = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("disabled SOF ds_reset", ds_reset, 1);
        checkOutput("disabled SOF busy", busy, 0);
        @(negedge clock); enable = 1'b1;

        // Contiguous frame
        d0 = doneCount; f0 = fwdCount;
        doFrame(8'd1, 1'b0, 4'b0011, 4'b0000, 1'b0);
        checkOutput("f1 frame_done", frame_done, 1);
        checkOutput("f1 frame_out_count", frame_out_count, 2);
        checkOutput("f1 errors", {err_early_sof, err_overrun, err_count}, 0);
        checkOutput("f1 ds_reset after", ds_reset, 1);
        checkOutput("f1 busy after", busy, 0);
        checkOutput("f1 forwarded", fwdCount - f0, 8);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("f1 frame_done single", frame_done, 0);
        checkOutput("f1 done pulses", doneCount - d0, 1);

        // Gapped frame
        d0 = doneCount; f0 = fwdCount;
        doFrame(8'h10, 1'b1, 4'b0110, 4'b0000, 1'b0);
        checkOutput("f2 frame_done", frame_done, 1);
        checkOutput("f2 frame_out_count", frame_out_count, 2);
        checkOutput("f2 forwarded", fwdCount - f0, 8);
        checkOutput("f2 done pulses", doneCount - d0, 1);

        // Early SOF at pixel 5 aborts the frame
        d0 = doneCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i == 0, 8'h70 + DW'(i), 1'b0, 1'b0);
            expQ.push_back(8'h70 + DW'(i));
        end
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("esof flag", err_early_sof, 1);
        checkOutput("esof ds_reset", ds_reset, 1);
        checkOutput("esof busy", busy, 0);
        repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("esof no frame_done", doneCount - d0, 0);
        checkOutput("esof count unchanged", frame_out_count, 2);
        doFrame(8'h20, 1'b0, 4'b0011, 4'b0000, 1'b0);
        checkOutput("esof next frame_done", frame_done, 1);
        checkOutput("esof sticky", err_early_sof, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("esof cleared", err_early_sof, 0);

        // Short output count, then clear racing a second bad frame end
        doFrame(8'h30, 1'b0, 4'b0100, 4'b0000, 1'b0);
        checkOutput("bad count value", frame_out_count, 1);
        checkOutput("bad count flag", err_count, 1);
        doFrame(8'h40, 1'b0, 4'b0001, 4'b0000, 1'b1);
        checkOutput("set beats clear", err_count, 1);
        checkOutput("bad count frame_done", frame_done, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("count err cleared", err_count, 0);

        // Overrun in second drain cycle, output on last drain cycle
        doFrame(8'h50, 1'b0, 4'b1001, 4'b0010, 1'b0);
        checkOutput("overrun flag", err_overrun, 1);
        checkOutput("overrun last-cycle count", frame_out_count, 2);
        checkOutput("overrun count ok", err_count, 0);

        // Reset mid-frame after 3 pixels
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i == 0, 8'h90 + DW'(i), 1'b0, 1'b0);
            expQ.push_back(8'h90 + DW'(i));
        end
        @(negedge clock);
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; ds_out_valid = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("mid reset ds_reset", ds_reset, 1);
        checkOutput("mid reset ds_valid", ds_valid, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset frame_out_count", frame_out_count, 0);
        checkOutput("mid reset errors", {err_early_sof, err_overrun, err_count}, 0);
        reset = 1'b0; ds_out_valid = 1'b0;
        doFrame(8'h60, 1'b0, 4'b0011, 4'b0000, 1'b0);
        checkOutput("post reset frame_done", frame_done, 1);
        checkOutput("post reset frame_out_count", frame_out_count, 2);
        checkOutput("post reset err_count", err_count, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/downsampler_frame_sequencer.md
Name: downsampler_frame_sequencer

Overview:
Frame-level controller that sits between the camera pixel stream and the grayscale binning downsampler. It holds the downsampler in reset between frames and releases it on start-of-frame. It gates and registers pixels into the downsampler, tracks raster position, and counts binned outputs. It reports frame completion and protocol errors to the host-side status logic.

Parameters:
IMAGE_WIDTH, 320, pixels per input line
IMAGE_HEIGHT, 240, lines per input frame
BIN_WIDTH, 2, downsampler horizontal bin size; used only for expected output count
BIN_HEIGHT, 2, downsampler vertical bin size; used only for expected output count
DATA_WIDTH, 8, pixel width
DRAIN_CYCLES, 4, cycles waited after last forwarded pixel for the downsampler pipeline to empty (>=1)
COUNT_WIDTH, 16, width of frame_out_count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  allow a new frame to start; sampled only in IDLE
pix_valid  in  1  input pixel strobe
pix_sof  in  1  start of frame; qualified by pix_valid, marks the first pixel
pix_data  in  DATA_WIDTH  input pixel
ds_reset  out  1  reset to downsampler; registered
ds_valid  out  1  pixel strobe to downsampler; registered
ds_data  out  DATA_WIDTH  pixel to downsampler; registered
ds_out_valid  in  1  downsampler output strobe, counted here
busy  out  1  high in ACTIVE or DRAIN
frame_done  out  1  one-cycle pulse at end of each completed frame
frame_out_count  out  COUNT_WIDTH  ds_out_valid count of the last completed frame
err_early_sof  out  1  sticky: pix_sof seen mid-frame
err_overrun  out  1  sticky: pix_valid seen during DRAIN
err_count  out  1  sticky: frame output count != EXPECTED
err_clear  in  1  clears all sticky errors

Behaviour:
- EXPECTED = ceil(IMAGE_WIDTH/BIN_WIDTH) * ceil(IMAGE_HEIGHT/BIN_HEIGHT); localparam.
- Reset values: ds_reset=1, ds_valid=0, ds_data=0, busy=0, frame_done=0, frame_out_count=0, all err_*=0. State=IDLE. x, y, drain and output counters = 0.
- Reset asserted in any state aborts the frame immediately. Nothing is reported.
- IDLE: ds_reset=1, ds_valid=0. Non-SOF pixels are dropped silently.
  - If enable && pix_valid && pix_sof: the next cycle has ds_reset=0, ds_valid=1, ds_data=pix_data. Set x=1, y=0, out count=0, go ACTIVE.
  - Forwarding latency is exactly 1 cycle in all states.
- ACTIVE: each pix_valid without pix_sof is forwarded (ds_valid=1 next cycle) and advances x.
  - x wraps at IMAGE_WIDTH-1 to 0, incrementing y.
  - The pixel at x=IMAGE_WIDTH-1, y=IMAGE_HEIGHT-1 is forwarded, then go DRAIN with drain counter=0.
  - Cycles without pix_valid give ds_valid=0; position holds.
- ACTIVE with pix_valid && pix_sof: pixel dropped, err_early_sof set. Next cycle ds_reset=1, go IDLE. No frame_done, frame_out_count unchanged.
  - That SOF is not restarted; the next SOF is required.
- DRAIN: ds_valid=0.
  - Any pix_valid is dropped and sets err_overrun; pix_sof is ignored.
  - Drain counter increments each cycle. On the cycle it equals DRAIN_CYCLES-1, go IDLE.
- On the DRAIN->IDLE cycle, all of these take effect together in the next cycle:
  - frame_done pulses.
  - frame_out_count loads the final count.
  - err_count sets if final != EXPECTED.
  - ds_reset returns to 1.
- ds_out_valid is counted in ACTIVE and DRAIN, including the final DRAIN cycle. It is ignored in IDLE. The counter saturates at all-ones.
- enable is checked only at SOF acceptance; dropping it mid-frame does not abort the frame.
- err_clear clears sticky flags next cycle. A set event in the same cycle wins.
- busy = state in {ACTIVE, DRAIN}, registered with the state.

Test Plan:
- IMAGE 4x2, BIN 2x2, DRAIN 4, enable=1. SOF + 8 contiguous pixels 1..8, ds_out_valid pulsed twice in DRAIN -> ds_valid high 8 consecutive cycles 1 cycle later, ds_data=1..8, ds_reset=0 throughout; frame_done once, frame_out_count=2, no errors, ds_reset=1 after.
- Same frame with pix_valid gapped every other cycle -> ds_valid mirrors the gaps with 1-cycle latency; 8 forwarded pixels; frame_done once.
- SOF at pixel 5 of a frame -> pixel dropped, err_early_sof=1, ds_reset=1 next cycle, no frame_done; next clean frame completes, err_early_sof stays 1 until err_clear.
- Only 1 ds_out_valid pulse during a frame -> frame_out_count=1, err_count=1; err_clear concurrent with a second bad frame end -> err_count stays 1.
- pix_valid in the 2nd DRAIN cycle, and ds_out_valid on the last DRAIN cycle -> pixel not forwarded, err_overrun=1; the last-cycle output is counted.
- reset mid-ACTIVE (after 3 pixels) -> next cycle all outputs at reset values; next SOF starts a clean frame with frame_out_count correct.
